pipelined_shifter: RTL
======================

# pipelined_shifter

Parametrised, pipelined barrel shifter for the vALU datapath. Shifts or rotates a WIDTH-bit operand by the low log2(WIDTH) bits of a second operand. Supports logical or arithmetic fill, left or right direction, and rotate. Operations enter and leave through a valid/ready handshake with full back-pressure, so the block drops into a multi-cycle ALU issue path without an external stall controller.

## Interface
- WIDTH, 32, operand/result width; power of two, >= 2.
- REG_EVERY, 1, number of shift layers between pipeline registers; 1..SHAMT_W.
- TAG_W, 4, width of the opaque tag carried alongside each operation; >= 1.
- SHAMT_W (localparam), clog2(WIDTH), number of shift layers and shift-amount bits used.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operation offered.
- in_ready  output  1  block accepts the operation this cycle.
- in_a  input  WIDTH  operand to shift.
- in_b  input  WIDTH  shift amount; only in_b[SHAMT_W-1:0] is used, upper bits are ignored.
- in_logical  input  1  1 = logical (zero fill), 0 = arithmetic (sign fill on right shift).
- in_right  input  1  1 = right, 0 = left.
- in_rotate  input  1  1 = rotate; overrides in_logical.
- in_tag  input  TAG_W  passed through unchanged.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result this cycle.
- out_data  output  WIDTH  result.
- out_tag  output  TAG_W  tag of the result.

## Operation
- Transfer occurs on a clock edge where valid && ready, on both the input and output sides.
- Result semantics, with n = in_b[SHAMT_W-1:0]:
  - Left, not rotate: a << n, zero fill. Arithmetic and logical left are identical.
  - Right, logical: a >> n, zero fill.
  - Right, arithmetic: a >>> n, fill with a[WIDTH-1].
  - Rotate: bits leaving one end re-enter at the other, in the selected direction.
- n = 0 returns a unchanged in every mode.
- Structure: SHAMT_W mux layers. Layer i shifts by 2^i when n[i] = 1. The fill bit is computed once per operation. Right operations may be implemented by bit-reversing, shifting left, then reversing back.
- Pipeline: L = ceil(SHAMT_W / REG_EVERY) register stages. The register follows every REG_EVERY-th layer, and the final register drives out_data/out_tag directly.
- Each stage holds a valid bit, the partial result, the remaining shift bits, the mode bits, fill and tag.
- Stage k advances when its successor is empty or advancing. The last stage advances when out_ready = 1.
- in_ready = !valid_0 || advance_0. Bubbles collapse, so a stalled output does not block input until all L stages are full.
- A stalled stage holds all of its contents stable. out_data/out_tag do not change while out_valid && !out_ready.
- Results leave in acceptance order. No reordering, duplication or loss.

## Timing
- Reset (rst_n low, takes effect asynchronously):
  - All stage valid bits, out_valid, out_data and out_tag go to 0.
  - in_ready reads 1 after the first clock edge following release.
  - Operations in flight are discarded.
- Latency: an op accepted at edge t presents out_valid at edge t+L when it is not stalled. Example: WIDTH=32, REG_EVERY=1 gives L=5. REG_EVERY=SHAMT_W gives L=1.
- Throughput: one op per cycle while out_ready is held high.
- Capacity: L ops in flight. in_ready falls combinationally when the pipeline is full and out_ready = 0.
- in_ready depends combinationally on out_ready through the advance chain. The design has no combinational path from in_* data to out_*.
- Simultaneous accept and emit in the same cycle with a full pipeline is legal and keeps occupancy at L.

## Test plan
- WIDTH=32, REG_EVERY=1, logical right: a=0x80000000, b=4 -> out_data 0x08000000 exactly 5 cycles after accept. Left: a=0x0000000F, b=28 -> 0xF0000000.
- Arithmetic right: a=0x80000000, b=31 -> 0xFFFFFFFF. a=0x7FFFFFFF, b=31 -> 0x00000000. Arithmetic left: a=0x00000001, b=31 -> 0x80000000.
- Rotate right: a=0x00000001, b=1 -> 0x80000000. Rotate left: a=0x80000001, b=4 -> 0x00000018. Upper in_b bits ignored: b=0xFFFFFFE3 -> shift by 3.
- Back-pressure: stream 8 ops with tags 0..7 back-to-back and hold out_ready low for 6 cycles mid-stream.
  - in_ready falls once 5 ops are held.
  - out_data/out_tag stay stable while stalled.
  - All 8 results emerge in tag order with no loss.
- Reset mid-operation: pull rst_n low with 3 ops in flight, asynchronously to clk.
  - out_valid drops to 0 immediately.
  - After release, no stale result appears and the next op completes correctly.
- Parameter sweep: WIDTH=8, REG_EVERY=3 -> L=1. Check all 8 amounts × 6 modes against a reference model; b=0 -> a unchanged.

Source files
------------

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter/rotator with valid/ready handshake and full back-pressure.
// Right operations are done as reverse -> shift left -> reverse, so every layer is a left shifter.
module pipelined_shifter #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 1,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_logical,
  input  logic             in_right,
  input  logic             in_rotate,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int L       = (SHAMT_W + REG_EVERY - 1) / REG_EVERY;

  logic [L-1:0]       valid_q;
  logic [L-1:0]       right_q;
  logic [L-1:0]       rot_q;
  logic [L-1:0]       fill_q;
  logic [WIDTH-1:0]   data_q [L];
  logic [SHAMT_W-1:0] sh_q   [L];
  logic [TAG_W-1:0]   tag_q  [L];

  logic [L-1:0]       adv;
  logic [L-1:0]       src_valid;
  logic [L-1:0]       src_right;
  logic [L-1:0]       src_rot;
  logic [L-1:0]       src_fill;
  logic [WIDTH-1:0]   src_data [L];
  logic [SHAMT_W-1:0] src_sh   [L];
  logic [TAG_W-1:0]   src_tag  [L];
  logic [WIDTH-1:0]   nxt_data [L];
  logic               unused_bits;

  function automatic logic [WIDTH-1:0] reverse(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int j = 0; j < WIDTH; j++) r[j] = x[WIDTH-1-j];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] shift_layer(input logic [WIDTH-1:0] x, input int s,
                                                   input logic rot, input logic fill);
    logic [WIDTH-1:0] low_mask;
    low_mask = ~({WIDTH{1'b1}} << s);
    if (rot) return (x << s) | (x >> (WIDTH - s));
    return (x << s) | (fill ? low_mask : '0);
  endfunction

  // Stage 0 is fed from the ports; the fill bit is decided once here and carried along.
  always_comb begin
    src_valid[0] = in_valid;
    src_right[0] = in_right;
    src_rot[0]   = in_rotate;
    src_fill[0]  = in_right && !in_logical && !in_rotate && in_a[WIDTH-1];
    src_data[0]  = in_right ? reverse(in_a) : in_a;
    src_sh[0]    = in_b[SHAMT_W-1:0];
    src_tag[0]   = in_tag;
    for (int k = 1; k < L; k++) begin
      src_valid[k] = valid_q[k-1];
      src_right[k] = right_q[k-1];
      src_rot[k]   = rot_q[k-1];
      src_fill[k]  = fill_q[k-1];
      src_data[k]  = data_q[k-1];
      src_sh[k]    = sh_q[k-1];
      src_tag[k]   = tag_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < L; k++) begin
      nxt_data[k] = src_data[k];
      for (int i = 0; i < SHAMT_W; i++) begin
        if ((i / REG_EVERY) == k && src_sh[k][i])
          nxt_data[k] = shift_layer(nxt_data[k], 1 << i, src_rot[k], src_fill[k]);
      end
      if (k == L - 1 && src_right[k]) nxt_data[k] = reverse(nxt_data[k]);
    end
  end

  // A stage advances while some later stage is empty or the consumer is taking the result.
  always_comb begin
    logic hole;
    hole = out_ready;
    adv  = '0;
    for (int k = L - 1; k >= 0; k--) begin
      adv[k] = valid_q[k] && hole;
      hole   = hole || !valid_q[k];
    end
  end

  assign in_ready = !valid_q[0] || adv[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      right_q <= '0;
      rot_q   <= '0;
      fill_q  <= '0;
      for (int k = 0; k < L; k++) begin
        data_q[k] <= '0;
        sh_q[k]   <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < L; k++) begin
        if (!valid_q[k] || adv[k]) begin
          valid_q[k] <= src_valid[k];
          if (src_valid[k]) begin
            data_q[k]  <= nxt_data[k];
            sh_q[k]    <= src_sh[k];
            right_q[k] <= src_right[k];
            rot_q[k]   <= src_rot[k];
            fill_q[k]  <= src_fill[k];
            tag_q[k]   <= src_tag[k];
          end
        end
      end
    end
  end

  assign out_valid = valid_q[L-1];
  assign out_data  = data_q[L-1];
  assign out_tag   = tag_q[L-1];

  assign unused_bits = ^{in_b[WIDTH-1:SHAMT_W], sh_q[L-1], right_q[L-1], rot_q[L-1], fill_q[L-1]};

endmodule
